// File: rtl/gst_snd_pkg.sv
// Shared types and helpers for the STE sound FIFO: playback rate codes and tick period.
package gst_snd_pkg;

  typedef enum logic [1:0] {
    RATE_6K  = 2'd0,
    RATE_12K = 2'd1,
    RATE_25K = 2'd2,
    RATE_50K = 2'd3
  } rate_e;

  localparam int unsigned BASE_DIV_DEF = 640;

  // clk cycles per sample: the fastest rate divides by base, each slower step doubles it
  function automatic int unsigned rate_period(input rate_e r, input int unsigned base);
    return base << (2'd3 - 2'(r));
  endfunction

endpackage

// File: rtl/gst_wordfifo.sv
// Small synchronous 16-bit word FIFO with a synchronous flush and a registered word count.
module gst_wordfifo
  import gst_snd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resb,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [15:0]                i_wdata,
  output logic [15:0]                o_rdata_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_rdata_c = r_mem[r_rd];
  assign o_count   = r_count;

  // A push while full is only accepted when a pop frees the slot in the same cycle
  assign w_do_pop  = i_pop && !o_empty_c && !i_flush;
  assign w_do_push = i_push && (!o_full_c || w_do_pop) && !i_flush;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/gst_sndfifo.sv
// STE sound DMA sink: catches MCU word strobes into a FIFO and plays them out as
// signed 8-bit L/R samples at the selected rate, requesting refills via sreq.
module gst_sndfifo
  import gst_snd_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BASE_DIV = BASE_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   resb,
  input  logic                   sload_n,
  input  logic [15:0]            d,
  input  logic                   sndon,
  input  logic                   mono,
  input  logic [1:0]             rate,
  output logic                   sreq,
  output logic [7:0]             smp_l,
  output logic [7:0]             smp_r,
  output logic                   smp_stb,
  output logic                   underrun,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(BASE_DIV * 8);

  logic             r_sload_n;
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase_hi;
  logic             r_sreq;
  logic [7:0]       r_smp_l;
  logic [7:0]       r_smp_r;
  logic             r_stb;
  logic             r_und;
  logic             r_ovf;

  logic             w_load;
  logic             w_tick;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_full;
  logic             w_empty;
  logic [15:0]      w_head;
  logic [LVL_W-1:0] w_count;
  logic [LVL_W-1:0] w_level_nxt;
  logic [CNT_W-1:0] w_reload;
  logic [7:0]       w_byte;

  gst_wordfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resb      (resb),
    .i_flush   (!sndon),
    .i_push    (w_load),
    .i_pop     (w_pop),
    .i_wdata   (d),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // One write per falling edge of the load strobe, however long it stays low
  assign w_load      = sndon && !sload_n && r_sload_n;
  assign w_tick      = sndon && r_run && (r_cnt == '0);
  assign w_pop       = w_tick && !w_empty && (!mono || !r_phase_hi);
  assign w_push_ok   = w_load && (!w_full || w_pop);
  assign w_level_nxt = sndon ? LVL_W'(w_count + LVL_W'(w_push_ok) - LVL_W'(w_pop)) : '0;
  assign w_reload    = CNT_W'(rate_period(rate_e'(rate), BASE_DIV) - 1);
  assign w_byte      = r_phase_hi ? w_head[15:8] : w_head[7:0];

  assign sreq     = r_sreq;
  assign smp_l    = r_smp_l;
  assign smp_r    = r_smp_r;
  assign smp_stb  = r_stb;
  assign underrun = r_und;
  assign overflow = r_ovf;
  assign level    = w_count;

  // Rate divider: first reload happens on the first sndon cycle, later ones on each tick
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (!sndon) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (!r_run) begin
      r_run <= 1'b1;
      r_cnt <= w_reload;
    end else if (r_cnt == '0) begin
      r_cnt <= w_reload;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_sload_n  <= 1'b1;
      r_phase_hi <= 1'b1;
      r_sreq     <= 1'b0;
      r_smp_l    <= '0;
      r_smp_r    <= '0;
      r_stb      <= 1'b0;
      r_und      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_sload_n <= sload_n;
      r_sreq    <= sndon && (w_level_nxt < LVL_W'(DEPTH));
      r_stb     <= w_tick && !w_empty;
      r_und     <= w_tick && w_empty;
      r_ovf     <= w_load && w_full && !w_pop;
      if (!sndon) begin
        r_phase_hi <= 1'b1;
      end else if (w_tick && !w_empty) begin
        // A stereo pop always lands on a word boundary, so the phase restarts high
        r_phase_hi <= mono ? !r_phase_hi : 1'b1;
        if (mono) begin
          r_smp_l <= w_byte;
          r_smp_r <= w_byte;
        end else begin
          r_smp_l <= w_head[15:8];
          r_smp_r <= w_head[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_gst_sndfifo.sv
// Scoreboard bench for gst_sndfifo: expected samples queued at load time, checked on each strobe.
module tb_gst_sndfifo;

  localparam int unsigned DEPTH = 4;
  localparam int P_FAST = 640;
  localparam int P_SLOW = 5120;

  logic        clk = 1'b0;
  logic        resb = 1'b0;
  logic        sload_n = 1'b1;
  logic [15:0] d = '0;
  logic        sndon = 1'b0;
  logic        mono = 1'b0;
  logic [1:0]  rate = '0;
  logic        sreq;
  logic [7:0]  smp_l;
  logic [7:0]  smp_r;
  logic        smp_stb;
  logic        underrun;
  logic        overflow;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_stb = 0;
  int n_und = 0;
  int n_ovf = 0;
  int stb_cyc = 0;
  int stb_prev = 0;
  int t_on = 0;
  int base_ovf;
  int base_und;
  int base_stb;
  logic [15:0] sb[$];

  gst_sndfifo #(.DEPTH(DEPTH), .BASE_DIV(640)) dut (
    .clk      (clk),
    .resb     (resb),
    .sload_n  (sload_n),
    .d        (d),
    .sndon    (sndon),
    .mono     (mono),
    .rate     (rate),
    .sreq     (sreq),
    .smp_l    (smp_l),
    .smp_r    (smp_r),
    .smp_stb  (smp_stb),
    .underrun (underrun),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: each strobe pops the next expected L/R pair
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    if (smp_stb === 1'b1) begin
      n_stb++;
      stb_prev = stb_cyc;
      stb_cyc  = cyc;
      if (sb.size() == 0) begin
        check_eq("stb_unexpected", 32'(smp_stb), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("smp_l", 32'(smp_l), 32'(e[15:8]));
        check_eq("smp_r", 32'(smp_r), 32'(e[7:0]));
      end
    end
    if (underrun === 1'b1) n_und++;
    if (overflow === 1'b1) n_ovf++;
  end

  task automatic load(input logic [15:0] w);
    sload_n = 1'b0;
    d       = w;
    @(negedge clk);
    sload_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start(input logic [1:0] r, input logic m);
    rate  = r;
    mono  = m;
    sndon = 1'b1;
    t_on  = cyc;
  endtask

  task automatic stop();
    sndon = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_stb(input int target, input int budget, input string tag);
    int k = 0;
    while (n_stb < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(n_stb), 32'(target));
  endtask

  task automatic wait_und(input int target, input int budget, input string tag);
    int k = 0;
    while (n_und < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(n_und), 32'(target));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_sreq", 32'(sreq), 32'd0);
    check_eq("rst_smp_l", 32'(smp_l), 32'd0);
    check_eq("rst_smp_r", 32'(smp_r), 32'd0);
    check_eq("rst_stb", 32'(smp_stb), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_und", 32'(underrun), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    resb = 1'b1;
    @(negedge clk);

    // Stereo at the fastest rate, two words then an empty tick
    start(2'd3, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("sreq_on", 32'(sreq), 32'd1);
    check_eq("idle_level", 32'(level), 32'd0);
    load(16'h7F80); sb.push_back(16'h7F80);
    load(16'h0102); sb.push_back(16'h0102);
    check_eq("st_level2", 32'(level), 32'd2);
    wait_stb(1, 2000, "st_stb1_timeout");
    check_eq("st_stb1_lat", 32'(stb_cyc - t_on), 32'(P_FAST + 1));
    wait_stb(2, 2000, "st_stb2_timeout");
    check_eq("st_period", 32'(stb_cyc - stb_prev), 32'(P_FAST));
    check_eq("st_level0", 32'(level), 32'd0);
    base_und = n_und;
    wait_und(base_und + 1, 1000, "st_underrun");
    check_eq("st_hold_l", 32'(smp_l), 32'h01);
    check_eq("st_hold_r", 32'(smp_r), 32'h02);
    check_eq("st_no_stb", 32'(n_stb), 32'd2);
    stop();
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_sreq", 32'(sreq), 32'd0);

    // Mono at the slowest rate: high byte, then low byte with pop
    start(2'd0, 1'b1);
    @(negedge clk);
    load(16'hA55A); sb.push_back(16'hA5A5); sb.push_back(16'h5A5A);
    check_eq("mo_level1", 32'(level), 32'd1);
    wait_stb(3, 6000, "mo_stb1_timeout");
    check_eq("mo_stb1_lat", 32'(stb_cyc - t_on), 32'(P_SLOW + 1));
    check_eq("mo_level_hold", 32'(level), 32'd1);
    wait_stb(4, 6000, "mo_stb2_timeout");
    check_eq("mo_period", 32'(stb_cyc - stb_prev), 32'(P_SLOW));
    check_eq("mo_level0", 32'(level), 32'd0);
    stop();

    // Fill, overflow, then a load coincident with a stereo tick while full
    start(2'd3, 1'b0);
    @(negedge clk);
    base_ovf = n_ovf;
    load(16'h1111); sb.push_back(16'h1111);
    load(16'h2222); sb.push_back(16'h2222);
    load(16'h3333); sb.push_back(16'h3333);
    load(16'h4444); sb.push_back(16'h4444);
    check_eq("full_level", 32'(level), 32'd4);
    check_eq("full_sreq", 32'(sreq), 32'd0);
    load(16'h5555);
    check_eq("ovf_pulse", 32'(n_ovf - base_ovf), 32'd1);
    check_eq("ovf_level", 32'(level), 32'd4);
    while (cyc < t_on + P_FAST) @(negedge clk);
    sload_n = 1'b0;
    d       = 16'h6666;
    sb.push_back(16'h6666);
    @(negedge clk);
    sload_n = 1'b1;
    check_eq("coin_stb", 32'(n_stb), 32'd5);
    check_eq("coin_lat", 32'(stb_cyc - t_on), 32'(P_FAST + 1));
    check_eq("coin_no_ovf", 32'(n_ovf - base_ovf), 32'd1);
    check_eq("coin_level", 32'(level), 32'd4);
    wait_stb(9, 4000, "drain_timeout");
    check_eq("drain_level", 32'(level), 32'd0);
    stop();

    // Long strobe counts once; dropping sndon flushes and silences
    start(2'd0, 1'b0);
    @(negedge clk);
    sload_n = 1'b0;
    d       = 16'hABCD;
    repeat (10) @(negedge clk);
    sload_n = 1'b1;
    @(negedge clk);
    check_eq("long_strobe_level", 32'(level), 32'd1);
    load(16'h1234);
    load(16'h5678);
    check_eq("hs_level3", 32'(level), 32'd3);
    check_eq("hs_sreq", 32'(sreq), 32'd1);
    sndon = 1'b0;
    @(negedge clk);
    check_eq("off_level", 32'(level), 32'd0);
    check_eq("off_sreq", 32'(sreq), 32'd0);
    base_stb = n_stb;
    base_und = n_und;
    repeat (6000) @(negedge clk);
    check_eq("off_no_stb", 32'(n_stb), 32'(base_stb));
    check_eq("off_no_und", 32'(n_und), 32'(base_und));

    // Asynchronous reset in the middle of operation
    start(2'd3, 1'b0);
    @(negedge clk);
    load(16'h0F0F);
    check_eq("pre_rst_level", 32'(level), 32'd1);
    resb = 1'b0;
    #1;
    check_eq("arst_level", 32'(level), 32'd0);
    check_eq("arst_sreq", 32'(sreq), 32'd0);
    check_eq("arst_smp_l", 32'(smp_l), 32'd0);
    sndon = 1'b0;
    @(negedge clk);
    resb = 1'b1;
    repeat (2) @(negedge clk);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gst_sndfifo.md
Name: gst_sndfifo

Overview:
- Downstream consumer of the MCU's sound DMA stage. Catches 16-bit words that the MCU strobes out with SLOAD_N and buffers them in a small word FIFO.
- Requests refills from the MCU through SREQ.
- Plays bytes out at the selected STE sample rate as signed 8-bit left/right samples with a strobe, for the DAC/mixer.

Parameters:
- DEPTH, 4: FIFO depth in 16-bit words (8 bytes), power of two, minimum 2.
- BASE_DIV, 640: clk cycles per sample at the fastest rate (≈50066 Hz from 32.04 MHz clk).

Ports:
- clk  input  1  system clock, same clk as the MCU.
- resb  input  1  asynchronous active-low reset.
- sload_n  input  1  MCU sound-load strobe, active low, synchronous to clk.
- d  input  16  data bus word, valid while sload_n is low.
- sndon  input  1  sound DMA enable.
- mono  input  1  1 = mono (one byte per sample), 0 = stereo (one word per sample).
- rate  input  2  0 = 6258, 1 = 12517, 2 = 25033, 3 = 50066 Hz.
- sreq  output  1  refill request to the MCU SREQ input.
- smp_l  output  8  left sample, two's complement.
- smp_r  output  8  right sample, two's complement.
- smp_stb  output  1  one-clk pulse when smp_l/smp_r update.
- underrun  output  1  one-clk pulse: a tick found no data.
- overflow  output  1  one-clk pulse: a load arrived while full and was dropped.
- level  output  $clog2(DEPTH)+1  current word count.

Behaviour:
- Reset (resb low, async): FIFO empty, level = 0, pointers = 0, byte phase = high. Outputs sreq = 0, smp_l = smp_r = 0, smp_stb = 0, underrun = 0, overflow = 0. Rate counter = 0.
- Load detect: sload_n is registered. A write occurs in the cycle where sload_n = 0 and its previous value was 1 (falling edge). d is captured in that same cycle. A low level held for many cycles is one write.
- Rate tick: down-counter reloads with (BASE_DIV << (3 - rate)) - 1 and pulses tick on reaching 0. First tick comes BASE_DIV << (3 - rate) cycles after sndon rises. A rate change takes effect at the next reload.
- Stereo tick, FIFO non-empty: pop one word. smp_l = word[15:8], smp_r = word[7:0]. smp_stb pulses in the cycle after the tick (latency 1).
- Mono tick: output head byte to both channels. Phase high → word[15:8], no pop, phase ← low. Phase low → word[7:0], pop, phase ← high.
- Tick with FIFO empty:
  - smp_l/smp_r hold their value.
  - smp_stb stays 0.
  - underrun pulses.
  - Byte phase is unchanged.
- Write while full with no simultaneous pop: word dropped, overflow pulses, level unchanged.
- Write and pop in the same cycle: both take effect and level is unchanged. This also applies when full, where the write is accepted and no overflow occurs.
- Pointers wrap modulo DEPTH. level ranges over 0..DEPTH.
- sreq is registered: sreq = sndon && (level_next < DEPTH). It deasserts the cycle after the FIFO becomes full.
- sndon low:
  - Synchronous flush: level = 0, phase = high, rate counter = 0.
  - Writes ignored, no ticks, sreq = 0.
  - smp_l/smp_r hold their value.
- Reset mid-operation: all state returns to reset values immediately. No strobe is produced.
- mono changing mid-word: the new mode applies from the next tick. If in low phase, the next mono tick outputs the low byte, then pops.

Decomposition:
- Package gst_snd_pkg:
  - rate enum RATE_6K/12K/25K/50K.
  - BASE_DIV default.
  - Function rate_period(rate).
- Sub-module gst_wordfifo: synchronous 16-bit FIFO with push, pop, full, empty, count and async active-low reset (resb).
- Top block: load detect, rate counter, byte phase, output registers.

Test Plan:
- Reset then sndon = 1, level = 0 → sreq = 1 two cycles after sndon rises. smp_l = smp_r = 0.
- Stereo, rate = 3, preload 0x7F80, 0x0102 → first smp_stb 640 cycles after sndon with L = 0x7F, R = 0x80. Second at 1280 with L = 0x01, R = 0x02. Third tick (empty) → underrun pulse, outputs held at 0x01/0x02.
- Mono, rate = 0, load 0xA55A → ticks every 5120 cycles. Outputs L = R = 0xA5 then L = R = 0x5A. level goes 1 → 1 → 0.
- Five loads with no ticks, DEPTH = 4 → level = 4, sreq = 0, fifth load pulses overflow, and later output shows only the first four words.
- Full FIFO, load coincident with stereo tick → no overflow, level stays 4, popped word equals the oldest word.
- sreq handshake: sload_n held low for 10 cycles → exactly one write. sndon dropped with level = 3 → level = 0, sreq = 0 next cycle, no further smp_stb.
